// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the VGA rectangle-fill engine.
// Framebuffer geometry, register window layout and STATUS bit positions.
package vga_pkg;

    localparam logic [31:0] BEGINNING_VGA = 32'hFF000000;
    localparam int          FB_WIDTH      = 320;
    localparam int          FB_HEIGHT     = 240;
    localparam logic [31:0] REG_BASE      = 32'hFF100000;

    // Word index inside the register window (byte offset >> 2)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ORIGIN = 2'd1;
    localparam logic [1:0] REG_SIZE   = 2'd2;
    localparam logic [1:0] REG_COLOR  = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_NEXT_ROW
    } fill_state_t;

endpackage

// File: rtl/vga_fill_engine_if.sv
// CPU IO-bus side and framebuffer-write side of the fill engine.
// The engine uses the slave modport; the bus/VGA side uses master.
interface vga_fill_engine_if;

    logic        wReadEnable;
    logic        wWriteEnable;
    logic [31:0] wAddress;
    logic [31:0] wWriteData;
    logic        iGrant;
    logic        oVGAWriteEnable;
    logic [31:0] oVGAAddress;
    logic [31:0] oVGAWriteData;
    logic [3:0]  oVGAByteEnable;
    logic        oIRQ;

    modport master (
        output wReadEnable, wWriteEnable, wAddress, wWriteData, iGrant,
        input  oVGAWriteEnable, oVGAAddress, oVGAWriteData, oVGAByteEnable, oIRQ
    );

    modport slave (
        input  wReadEnable, wWriteEnable, wAddress, wWriteData, iGrant,
        output oVGAWriteEnable, oVGAAddress, oVGAWriteData, oVGAByteEnable, oIRQ
    );

endinterface

// File: rtl/vga_fill_span.sv
// Per-row write generator: walks one row, issuing aligned full words where
// possible and single bytes at the ragged edges.
module vga_fill_span (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [8:0]  load_len,
    input  logic        advance,
    output logic [31:0] addr,
    output logic [3:0]  be,
    output logic        last
);

    logic [31:0] cur;
    logic [8:0]  rem;
    logic [8:0]  step;
    logic [31:0] nxt_cur;
    logic [8:0]  nxt_rem;

    function automatic logic is_word(input logic [31:0] a, input logic [8:0] n);
        return (a[1:0] == 2'b00) && (n >= 9'd4);
    endfunction

    function automatic logic [3:0] req_be(input logic [31:0] a, input logic [8:0] n);
        return is_word(a, n) ? 4'b1111 : (4'b0001 << a[1:0]);
    endfunction

    always_comb begin
        step    = is_word(cur, rem) ? 9'd4 : 9'd1;
        last    = (rem <= step);
        nxt_cur = cur + {23'b0, step};
        nxt_rem = rem - step;
    end

    // addr/be always describe the request held at cur/rem
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            rem  <= '0;
            addr <= '0;
            be   <= '0;
        end else if (load) begin
            cur  <= load_addr;
            rem  <= load_len;
            addr <= {load_addr[31:2], 2'b00};
            be   <= req_be(load_addr, load_len);
        end else if (advance) begin
            cur  <= nxt_cur;
            rem  <= nxt_rem;
            addr <= {nxt_cur[31:2], 2'b00};
            be   <= req_be(nxt_cur, nxt_rem);
        end
    end

endmodule

// File: rtl/vga_fill_engine.sv
// Memory-mapped rectangle fill for the 320x240x8bpp framebuffer: register
// file, bus decode, clipping and the row/run sequencer.
module vga_fill_engine
    import vga_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    vga_fill_engine_if.slave   bus,
    output logic [31:0]        wReadData
);

    fill_state_t state;
    logic [8:0]  org_x, size_w;
    logic [7:0]  org_y, size_h, color;
    logic        done, aborted, we, irq;
    logic [31:0] wdata;
    logic [31:0] row_addr;
    logic [8:0]  row_len;
    logic [7:0]  rows_left;

    logic        sel, busy, ctrl_wr, start_req, abort_req;
    logic [1:0]  reg_off;
    logic [31:0] rd;
    logic [9:0]  avail_w;
    logic [8:0]  avail_h, clip_w;
    logic [7:0]  clip_h;
    logic        clip_empty;
    logic [31:0] row_addr_c;
    logic        span_load, span_advance, span_last;
    logic [31:0] span_load_addr, span_addr;
    logic [8:0]  span_load_len;
    logic [3:0]  span_be;
    logic        unused_bits;

    function automatic logic [31:0] row_offset(input logic [7:0] y);
        logic [31:0] yy;
        yy = {24'b0, y};
        if (FB_WIDTH == 320) return (yy << 8) + (yy << 6);
        return yy * 32'(FB_WIDTH);
    endfunction

    assign sel         = (bus.wAddress[31:4] == REG_BASE[31:4]);
    assign reg_off     = bus.wAddress[3:2];
    assign busy        = (state != S_IDLE);
    assign ctrl_wr     = bus.wWriteEnable && sel && (reg_off == REG_CTRL);
    assign start_req   = ctrl_wr && bus.wWriteData[0];
    assign abort_req   = ctrl_wr && bus.wWriteData[1];
    assign unused_bits = ^{bus.wWriteData[31:24], bus.wWriteData[15:9], bus.wAddress[1:0]};

    always_comb begin
        rd = '0;
        case (reg_off)
            REG_CTRL: begin
                rd[ST_BUSY]    = busy;
                rd[ST_DONE]    = done;
                rd[ST_ABORTED] = aborted;
            end
            REG_ORIGIN: rd = {8'b0, org_y, 7'b0, org_x};
            REG_SIZE:   rd = {8'b0, size_h, 7'b0, size_w};
            default:    rd = {24'b0, color};
        endcase
    end

    assign wReadData = (bus.wReadEnable && sel) ? rd : 32'hzzzzzzzz;

    // Clipping against the framebuffer edges; wrapped differences only occur when empty is set
    always_comb begin
        avail_w    = 10'(FB_WIDTH) - {1'b0, org_x};
        clip_w     = ({1'b0, size_w} < avail_w) ? size_w : avail_w[8:0];
        avail_h    = 9'(FB_HEIGHT) - {1'b0, org_y};
        clip_h     = ({1'b0, size_h} < avail_h) ? size_h : avail_h[7:0];
        clip_empty = ({1'b0, org_x} >= 10'(FB_WIDTH)) || ({1'b0, org_y} >= 9'(FB_HEIGHT)) ||
                     (clip_w == 9'd0) || (clip_h == 8'd0);
        row_addr_c = BEGINNING_VGA + row_offset(org_y) + {23'b0, org_x};
    end

    assign span_load      = !abort_req && (((state == S_SETUP) && !clip_empty) || (state == S_NEXT_ROW));
    assign span_advance   = !abort_req && (state == S_RUN) && bus.iGrant && !span_last;
    assign span_load_addr = (state == S_SETUP) ? row_addr_c : row_addr;
    assign span_load_len  = (state == S_SETUP) ? clip_w : row_len;

    vga_fill_span u_span (
        .clk       (iCLK),
        .rst       (iRST),
        .load      (span_load),
        .load_addr (span_load_addr),
        .load_len  (span_load_len),
        .advance   (span_advance),
        .addr      (span_addr),
        .be        (span_be),
        .last      (span_last)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            org_x     <= '0;
            org_y     <= '0;
            size_w    <= '0;
            size_h    <= '0;
            color     <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            we        <= 1'b0;
            irq       <= 1'b0;
            wdata     <= '0;
            row_addr  <= '0;
            row_len   <= '0;
            rows_left <= '0;
        end else begin
            irq <= 1'b0;
            if (bus.wWriteEnable && sel && !busy) begin
                case (reg_off)
                    REG_ORIGIN: begin
                        org_x <= bus.wWriteData[8:0];
                        org_y <= bus.wWriteData[23:16];
                    end
                    REG_SIZE: begin
                        size_w <= bus.wWriteData[8:0];
                        size_h <= bus.wWriteData[23:16];
                    end
                    REG_COLOR: color <= bus.wWriteData[7:0];
                    default: ;
                endcase
            end
            if (busy && abort_req) begin
                state   <= S_IDLE;
                we      <= 1'b0;
                aborted <= 1'b1;
                done    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_req && !abort_req) begin
                            state   <= S_SETUP;
                            done    <= 1'b0;
                            aborted <= 1'b0;
                        end
                    end
                    S_SETUP: begin
                        if (clip_empty) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            irq   <= 1'b1;
                        end else begin
                            row_addr  <= row_addr_c;
                            row_len   <= clip_w;
                            rows_left <= clip_h;
                            wdata     <= {4{color}};
                            we        <= 1'b1;
                            state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (bus.iGrant && span_last) begin
                            we <= 1'b0;
                            if (rows_left > 8'd1) begin
                                state     <= S_NEXT_ROW;
                                row_addr  <= row_addr + 32'(FB_WIDTH);
                                rows_left <= rows_left - 8'd1;
                            end else begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                                irq   <= 1'b1;
                            end
                        end
                    end
                    S_NEXT_ROW: begin
                        we    <= 1'b1;
                        state <= S_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.oVGAWriteEnable = we;
    assign bus.oVGAAddress     = span_addr;
    assign bus.oVGAWriteData   = wdata;
    assign bus.oVGAByteEnable  = span_be;
    assign bus.oIRQ            = irq;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Scoreboard bench for vga_fill_engine: expected framebuffer writes are queued
// when a fill is started and matched as the engine presents them.
module tb_vga_fill_engine;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    wire [31:0] read_data;

    vga_fill_engine_if ifc();

    vga_fill_engine dut (
        .iCLK      (clk),
        .iRST      (rst),
        .bus       (ifc.slave),
        .wReadData (read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  irq_cnt = 0;
    int  gp[4]   = '{1, 0, 0, 1};

    localparam logic [31:0] A_CTRL  = REG_BASE;
    localparam logic [31:0] A_ORG   = REG_BASE + 32'h4;
    localparam logic [31:0] A_SIZE  = REG_BASE + 32'h8;
    localparam logic [31:0] A_COLOR = REG_BASE + 32'hC;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [3:0] be, input logic [7:0] c);
        wr_t e;
        e.addr = a;
        e.be   = be;
        e.data = {4{c}};
        exp_q.push_back(e);
    endtask

    // Reference walk: clip, then per row emit aligned words or single bytes
    task automatic push_model(input int x, input int y, input int w, input int h, input logic [7:0] c);
        int wc, hc, n;
        logic [31:0] a;
        if (x >= 320 || y >= 240) return;
        wc = (w < 320 - x) ? w : 320 - x;
        hc = (h < 240 - y) ? h : 240 - y;
        for (int r = 0; r < hc; r++) begin
            a = 32'hFF000000 + 32'((y + r) * 320 + x);
            n = wc;
            while (n > 0) begin
                if (a[1:0] == 2'b00 && n >= 4) begin
                    push_w(a, 4'b1111, c);
                    a = a + 4;
                    n = n - 4;
                end else begin
                    push_w({a[31:2], 2'b00}, 4'b0001 << a[1:0], c);
                    a = a + 1;
                    n = n - 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.oIRQ) irq_cnt++;
            if (ifc.oVGAWriteEnable) begin
                if (exp_q.size() == 0) begin
                    if (ifc.iGrant) check("spurious_we", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
                end else begin
                    check("wr_addr", ifc.oVGAAddress, exp_q[0].addr);
                    check("wr_be", {28'b0, ifc.oVGAByteEnable}, {28'b0, exp_q[0].be});
                    check("wr_data", ifc.oVGAWriteData, exp_q[0].data);
                    if (ifc.iGrant) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ifc.wAddress     = a;
        ifc.wWriteData   = d;
        ifc.wWriteEnable = 1'b1;
        @(posedge clk);
        #1;
        ifc.wWriteEnable = 1'b0;
        ifc.wWriteData   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ifc.wAddress    = a;
        ifc.wReadEnable = 1'b1;
        #1;
        d = read_data;
        ifc.wReadEnable = 1'b0;
    endtask

    task automatic start_fill(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                              input logic [7:0] h, input logic [7:0] c);
        bus_write(A_ORG, {8'h0, y, 7'h0, x});
        bus_write(A_SIZE, {8'h0, h, 7'h0, w});
        bus_write(A_COLOR, {24'h0, c});
        bus_write(A_CTRL, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n;
        logic [31:0] s;
        n = 0;
        do begin
            if (rnd) ifc.iGrant = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
            bus_read(A_CTRL, s);
        end while (s[ST_BUSY] && n < budget);
        check("busy_timeout", {31'b0, s[ST_BUSY]}, 32'd0);
        ifc.iGrant = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_of_fill(input string tag, input int irq0, input int irq_exp, input logic [2:0] st);
        logic [31:0] s;
        bus_read(A_CTRL, s);
        check({tag, "_status"}, 32'(s[2:0]), 32'(st));
        check({tag, "_irq"}, 32'(irq_cnt - irq0), 32'(irq_exp));
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        int irq0;
        ifc.wReadEnable  = 1'b0;
        ifc.wWriteEnable = 1'b0;
        ifc.wAddress     = '0;
        ifc.wWriteData   = '0;
        ifc.iGrant       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_we", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        check("rst_addr", ifc.oVGAAddress, 32'd0);
        check("rst_data", ifc.oVGAWriteData, 32'd0);
        check("rst_be", {28'b0, ifc.oVGAByteEnable}, 32'd0);
        check("rst_irq", {31'b0, ifc.oIRQ}, 32'd0);
        bus_read(A_CTRL, s);
        check("rst_status", s, 32'd0);
        bus_read(A_ORG, s);
        check("rst_origin", s, 32'd0);

        // Two aligned words in row 0
        irq0 = irq_cnt;
        push_w(32'hFF000000, 4'b1111, 8'h3C);
        push_w(32'hFF000004, 4'b1111, 8'h3C);
        start_fill(9'd0, 8'd0, 9'd8, 8'd1, 8'h3C);
        check("t1_we_n1", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        bus_read(A_CTRL, s);
        check("t1_busy", 32'(s[2:0]), 32'd1);
        @(posedge clk);
        #1;
        check("t1_we_n2", {31'b0, ifc.oVGAWriteEnable}, 32'd1);
        wait_idle(100, 1'b0);
        end_of_fill("t1", irq0, 1, 3'b010);

        // Ragged edges on two rows
        irq0 = irq_cnt;
        push_w(32'hFF000140, 4'b1000, 8'hA5);
        push_w(32'hFF000144, 4'b1111, 8'hA5);
        push_w(32'hFF000148, 4'b0001, 8'hA5);
        push_w(32'hFF000280, 4'b1000, 8'hA5);
        push_w(32'hFF000284, 4'b1111, 8'hA5);
        push_w(32'hFF000288, 4'b0001, 8'hA5);
        start_fill(9'd3, 8'd1, 9'd6, 8'd2, 8'hA5);
        wait_idle(100, 1'b0);
        end_of_fill("t2", irq0, 1, 3'b010);
        bus_read(A_ORG, s);
        check("t2_origin_rd", s, 32'h00010003);

        // Clipped at the bottom-right corner
        irq0 = irq_cnt;
        push_w(32'hFF012ABC, 4'b1111, 8'hC3);
        push_w(32'hFF012BFC, 4'b1111, 8'hC3);
        start_fill(9'd316, 8'd238, 9'd10, 8'd5, 8'hC3);
        wait_idle(100, 1'b0);
        end_of_fill("t3", irq0, 1, 3'b010);

        // Degenerate fills: zero width, origin off-screen
        for (int k = 0; k < 2; k++) begin
            irq0 = irq_cnt;
            if (k == 0) start_fill(9'd0, 8'd0, 9'd0, 8'd4, 8'h11);
            else        start_fill(9'd400, 8'd0, 9'd4, 8'd4, 8'h11);
            check("t4_irq_n1", {31'b0, ifc.oIRQ}, 32'd0);
            @(posedge clk);
            #1;
            check("t4_irq_n2", {31'b0, ifc.oIRQ}, 32'd1);
            bus_read(A_CTRL, s);
            check("t4_status", 32'(s[2:0]), 32'd2);
            @(posedge clk);
            #1;
            check("t4_irq_n3", {31'b0, ifc.oIRQ}, 32'd0);
            end_of_fill("t4", irq0, 1, 3'b010);
        end

        // Grant stalls: 4 bytes starting at an odd address
        irq0 = irq_cnt;
        push_w(32'hFF000280, 4'b0010, 8'h77);
        push_w(32'hFF000280, 4'b0100, 8'h77);
        push_w(32'hFF000280, 4'b1000, 8'h77);
        push_w(32'hFF000284, 4'b0001, 8'h77);
        start_fill(9'd1, 8'd2, 9'd4, 8'd1, 8'h77);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ifc.iGrant = gp[i][0];
        end
        wait_idle(100, 1'b0);
        end_of_fill("t5", irq0, 1, 3'b010);

        // Mixed pattern with random grants
        irq0 = irq_cnt;
        push_model(5, 10, 13, 3, 8'h5A);
        start_fill(9'd5, 8'd10, 9'd13, 8'd3, 8'h5A);
        wait_idle(1000, 1'b1);
        end_of_fill("t6", irq0, 1, 3'b010);

        // Abort after three granted writes
        irq0 = irq_cnt;
        push_w(32'hFF000000, 4'b1111, 8'h11);
        push_w(32'hFF000004, 4'b1111, 8'h11);
        push_w(32'hFF000008, 4'b1111, 8'h11);
        start_fill(9'd0, 8'd0, 9'd16, 8'd16, 8'h11);
        repeat (4) @(posedge clk);
        #1;
        ifc.iGrant = 1'b0;
        bus_write(A_CTRL, 32'd2);
        check("t7_we", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        ifc.iGrant = 1'b1;
        @(posedge clk);
        #1;
        check("t7_we_hold", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        end_of_fill("t7", irq0, 0, 3'b100);

        // START with ABORT in idle must not start
        bus_write(A_CTRL, 32'd3);
        bus_read(A_CTRL, s);
        check("t8_status", 32'(s[2:0]), 32'd4);

        // Busy-time register write ignored, then reset mid-run
        push_model(0, 0, 16, 16, 8'h66);
        start_fill(9'd0, 8'd0, 9'd16, 8'd16, 8'h66);
        bus_write(A_COLOR, 32'hFF);
        bus_read(A_COLOR, s);
        check("t9_color_hold", s, 32'h66);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        check("t9_we", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        check("t9_addr", ifc.oVGAAddress, 32'd0);
        check("t9_data", ifc.oVGAWriteData, 32'd0);
        check("t9_be", {28'b0, ifc.oVGAByteEnable}, 32'd0);
        bus_read(A_CTRL, s);
        check("t9_status", s, 32'd0);
        bus_read(A_COLOR, s);
        check("t9_color", s, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t9_we_after", {31'b0, ifc.oVGAWriteEnable}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
